vga_fb_line_scheduler: RTL and testbench

- Shares one single-port framebuffer RAM between VGA scanout and a pixel writer (drawing engine or CPU).
- Low-resolution framebuffer (FB_W x FB_H, each pixel replicated 2^SCALE_SHIFT times in x and y). Row fetches go into a double line buffer, and output pixels are derived from the VGA timing generator's xpos/ypos.
- Sits between the timing generator, framebuffer RAM, and colour output stage.
- Sequences row prefetch, bank swaps and writer arbitration.

---
 rtl/vga_fb_line_scheduler.sv | 176 +++++++++++++++++
 tb/tb_vga_fb_line_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_line_scheduler
// Brief    : Shares a single-port framebuffer RAM between VGA row prefetch
//            into a double line buffer and a pixel writer; drives scanout.
// Revision : 1.0
// ============================================================================
module vga_fb_line_scheduler #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              fetch_busy,
    output logic              underrun
);

    localparam int COL_W = $clog2(FB_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_disp_bank;
    logic                r_fetch_bank;
    logic [COL_W-1:0]    r_col;
    logic [ADDR_W-1:0]   r_base;
    logic                r_last_read;
    logic                r_cap_valid;
    logic [COL_W-1:0]    r_cap_col;
    logic                r_cap_bank;
    logic                r_underrun;
    logic [DATA_W-1:0]   r_pix_data;
    logic                r_pix_valid;
    logic [DATA_W-1:0]   r_lb [2][FB_W];

    logic [9:0]          w_yn;
    logic                w_line_evt;
    logic                w_swap;
    logic [9:0]          w_next_row;
    logic                w_prime;
    logic                w_start;
    logic [9:0]          w_start_row;
    logic                w_start_bank;
    logic                w_rd;
    logic                w_wr;
    logic                w_busy;

    assign w_yn        = ypos + 10'd1;
    assign w_line_evt  = (xpos == 10'(H_ACTIVE));
    assign w_swap      = w_line_evt && (w_yn < 10'(V_ACTIVE))
                         && (w_yn[SCALE_SHIFT-1:0] == '0);
    assign w_next_row  = (w_yn >> SCALE_SHIFT) + 10'd1;
    assign w_prime     = w_line_evt && (ypos == 10'(V_ACTIVE));
    assign w_start     = (w_swap && (w_next_row < 10'(FB_H))) || w_prime;
    assign w_start_row = w_prime ? 10'd0 : w_next_row;
    // On a swap the bank that just stopped being displayed becomes the back bank.
    assign w_start_bank = w_swap ? r_disp_bank : ~r_disp_bank;
    assign w_busy      = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE:  w_wr = wr_req;
            S_DRAIN: begin
                w_wr        = wr_req;
                w_state_nxt = S_IDLE;
            end
            S_FETCH: begin
                if (wr_req && r_last_read) begin
                    w_wr = 1'b1;
                end else begin
                    w_rd = 1'b1;
                    if (r_col == COL_W'(FB_W - 1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_start) begin
            w_state_nxt = S_FETCH;
        end
        // Nothing issues while reset is held, so a pending write is never acked.
        if (rst) begin
            w_rd = 1'b0;
            w_wr = 1'b0;
        end
    end

    assign mem_en     = w_rd || w_wr;
    assign mem_we     = w_wr;
    assign mem_addr   = w_wr ? wr_addr : (w_rd ? (r_base + ADDR_W'(r_col)) : '0);
    assign mem_wdata  = w_wr ? wr_data : '0;
    assign wr_ack     = w_wr;
    assign fetch_busy = w_busy;
    assign underrun   = r_underrun;
    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_disp_bank  <= 1'b0;
            r_fetch_bank <= 1'b0;
            r_col        <= '0;
            r_base       <= '0;
            r_last_read  <= 1'b0;
            r_cap_valid  <= 1'b0;
            r_cap_col    <= '0;
            r_cap_bank   <= 1'b0;
            r_underrun   <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_read <= w_rd;
            r_cap_valid <= w_rd;
            r_cap_col   <= r_col;
            r_cap_bank  <= r_fetch_bank;
            if (w_start) begin
                r_col        <= '0;
                r_base       <= ADDR_W'(w_start_row) * ADDR_W'(FB_W);
                r_fetch_bank <= w_start_bank;
            end else if (w_rd) begin
                r_col <= (r_col == COL_W'(FB_W - 1)) ? '0 : r_col + 1'b1;
            end
            if (w_swap) begin
                r_disp_bank <= ~r_disp_bank;
                if (w_busy) begin
                    r_underrun <= 1'b1;
                end
            end
            if (xpos < 10'(H_ACTIVE) && ypos < 10'(V_ACTIVE)) begin
                r_pix_data  <= r_lb[r_disp_bank][COL_W'(xpos >> SCALE_SHIFT)];
                r_pix_valid <= 1'b1;
            end else begin
                r_pix_data  <= '0;
                r_pix_valid <= 1'b0;
            end
        end
    end

    // Line buffer storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (r_cap_valid) begin
            r_lb[r_cap_bank][r_cap_col] <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_line_scheduler
// Brief    : Directed bench with a framebuffer RAM model holding RAM[a] = a[7:0].
// Revision : 1.0
// ============================================================================
module tb_vga_fb_line_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  xpos;
    logic [9:0]  ypos;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        fetch_busy;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    bit         ram_w [0:32767];
    logic [7:0] ram_d [0:32767];

    vga_fb_line_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .xpos       (xpos),
        .ypos       (ypos),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .fetch_busy (fetch_busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Unwritten locations read back as their own low address byte.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram_w[mem_addr] <= 1'b1;
                ram_d[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram_w[mem_addr] ? ram_d[mem_addr] : mem_addr[7:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic line_event(input logic [9:0] y, input int wait_cycles);
        xpos = 10'd640;
        ypos = y;
        tick();
        xpos = 10'd700;
        for (int i = 0; i < wait_cycles; i++) tick();
    endtask

    task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                         input logic [8:0] exp);
        xpos = x;
        ypos = y;
        tick();
        chk(tag, {23'd0, pix_valid, pix_data}, {23'd0, exp});
        xpos = 10'd700;
    endtask

    initial begin
        logic [18:0] exp_v;
        logic        quiet;
        rst = 1'b1; xpos = 10'd700; ypos = 10'd500;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk("reset_outputs", {25'd0, pix_valid, pix_data == 8'd0, fetch_busy, underrun,
                              wr_ack, mem_en, mem_addr == 15'd0},
            {25'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;

        // Prime row 0 at the vertical-blank line event.
        xpos = 10'd640; ypos = 10'd480;
        #1 chk("prime_evt_idle", {31'd0, mem_en}, 32'd0);
        tick();
        xpos = 10'd700;
        for (int c = 0; c < 160; c++) begin
            #1 chk("row0_read", {15'd0, mem_en, mem_we, mem_addr}, {15'd0, 1'b1, 1'b0, 15'(c)});
            tick();
        end
        #1 chk("row0_drain", {30'd0, fetch_busy, mem_en}, {30'd0, 1'b1, 1'b0});
        tick();
        chk("row0_done", {31'd0, fetch_busy}, 32'd0);

        // Row-1 fetch with the writer requesting continuously.
        xpos = 10'd640; ypos = 10'd1023;
        tick();
        xpos = 10'd700;
        wr_req = 1'b1; wr_addr = 15'h1234; wr_data = 8'h5A;
        for (int k = 0; k <= 320; k++) begin
            if (k == 320) wr_req = 1'b0;
            if (k == 320)
                exp_v = '0;
            else if (k == 319 || (k % 2) == 1)
                exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 15'h1234};
            else
                exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 15'(160 + k / 2)};
            #1 chk("arb_cycle", {13'd0, fetch_busy, mem_en, mem_we, wr_ack, mem_addr},
                   {13'd0, exp_v});
            tick();
        end

        // Line 0 shows row 0, line 4 shows row 1.
        pixel("l0_x0",   10'd0,   10'd0, 9'h100);
        pixel("l0_x3",   10'd3,   10'd0, 9'h100);
        pixel("l0_x4",   10'd4,   10'd0, 9'h101);
        pixel("l0_x639", 10'd639, 10'd0, 9'h19F);
        pixel("l0_x641", 10'd641, 10'd0, 9'h000);
        line_event(10'd3, 170);
        pixel("l4_x0",   10'd0,   10'd4, 9'h1A0);
        pixel("l4_x639", 10'd639, 10'd4, 9'h13F);

        for (int y = 7; y <= 115; y += 4) line_event(10'(y), 170);
        pixel("wr_pix",   10'd80, 10'd116, 9'h15A);
        pixel("wr_pix_b", 10'd80, 10'd119, 9'h15A);
        pixel("left_of",  10'd79, 10'd116, 9'h133);
        pixel("right_of", 10'd84, 10'd116, 9'h135);

        // Last swap of the frame has no row to fetch.
        line_event(10'd475, 0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (fetch_busy) quiet = 1'b0;
            tick();
        end
        line_event(10'd476, 0);
        if (fetch_busy) quiet = 1'b0;
        chk("no_fetch_row120", {31'd0, quiet}, 32'd1);
        line_event(10'd480, 0);
        #1 chk("prime_again", {16'd0, fetch_busy, mem_addr}, {16'd0, 1'b1, 15'd0});
        for (int i = 0; i < 50; i++) tick();
        chk("underrun_clear", {31'd0, underrun}, 32'd0);

        // Swap while busy: underrun and restart at column 0 of row 1.
        line_event(10'd1023, 0);
        #1 chk("restart", {15'd0, underrun, mem_en, mem_addr}, {15'd0, 1'b1, 1'b1, 15'd160});
        for (int i = 0; i < 170; i++) tick();
        chk("underrun_sticky", {30'd0, underrun, fetch_busy}, {30'd0, 1'b1, 1'b0});

        // Reset in the middle of a fetch with a write pending.
        line_event(10'd3, 20);
        chk("busy_pre_rst", {30'd0, fetch_busy, underrun}, {30'd0, 1'b1, 1'b1});
        rst = 1'b1; wr_req = 1'b1; wr_addr = 15'h0042; wr_data = 8'h77;
        #1 chk("rst_no_ack", {30'd0, wr_ack, mem_en}, 32'd0);
        tick();
        chk("rst_outputs", {8'd0, wr_ack, mem_en, mem_we, fetch_busy, underrun, pix_valid,
                            pix_data, mem_wdata}, 32'd0);
        rst = 1'b0;
        #1 chk("writer_idle", {1'd0, wr_ack, mem_en, mem_we, mem_addr, mem_wdata},
               {1'd0, 1'b1, 1'b1, 1'b1, 15'h0042, 8'h77});
        tick();
        wr_req = 1'b0;
        tick();
        chk("writer_ram", {24'd0, ram_d[15'h0042]}, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
